mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- Memory-stage load/store unit of the pipelined core. It sits between the execute/memory pipeline register and the memory/writeback pipeline register.
- Accepts a decoded access (address from ALUResultM, store data, funct3), runs a valid/ready request plus response handshake with data memory, and stalls the pipeline while waiting.
- Produces the sign/zero-extended ReadDataM that the writeback register captures.

Parameters:
DATA_WIDTH, 32, data and address width; logic is defined for 32 only (4 byte lanes)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
MemReadM  input  1  load in memory stage
MemWriteM  input  1  store in memory stage
Funct3M  input  3  access size/sign (RV32I load/store funct3)
ALUResultM  input  DATA_WIDTH  byte address
WriteDataM  input  DATA_WIDTH  store data (rs2)
ReadDataM  output  DATA_WIDTH  extended load result, valid in DONE
StallM  output  1  hold IF/ID/EX/M stages
MisalignM  output  1  one-cycle pulse, misaligned access dropped
mem_req_valid  output  1  request valid
mem_req_ready  input  1  memory accepts request
mem_req_we  output  1  1=write, 0=read
mem_addr  output  DATA_WIDTH  word address, bits[1:0]=0
mem_wdata  output  DATA_WIDTH  lane-replicated store data
mem_wstrb  output  4  byte-enable
mem_rsp_valid  input  1  read data valid
mem_rdata  input  DATA_WIDTH  read word

Behaviour:
- States: IDLE, REQ, WAIT_RSP, DONE. Reset (async, rst_n=0) forces IDLE. All registered outputs (ReadDataM, MisalignM, mem_req_valid, mem_req_we, mem_addr, mem_wdata, mem_wstrb) reset to 0.
- access = MemReadM | MemWriteM. If both are set, the access is a store (MemWriteM wins).
- StallM (combinational) = (state==IDLE & access) | state==REQ | state==WAIT_RSP. StallM=0 in DONE, so the writeback register captures ReadDataM at the DONE edge. IDLE with no access: StallM=0.
- Alignment: byte always aligned; half needs addr[0]=0; word needs addr[1:0]=0.
- IDLE & access & misaligned: no request issued. Next state DONE, MisalignM=1 for that DONE cycle, ReadDataM=0.
- IDLE & access & aligned: register mem_addr={addr[31:2],2'b00} and mem_req_we=MemWriteM. Store byte: wstrb=4'b0001<<addr[1:0], wdata={4{wd[7:0]}}. Store half: wstrb=4'b0011<<addr[1:0], wdata={2{wd[15:0]}}. Store word: wstrb=4'b1111, wdata=wd. Loads: wstrb=0. Record load type and addr[1:0]. Next state REQ.
- REQ: mem_req_valid=1. Request fields stay stable until mem_req_valid & mem_req_ready. On handshake: store goes to DONE, load goes to WAIT_RSP; mem_req_valid drops the following cycle.
- WAIT_RSP: on mem_rsp_valid, select a lane by addr[1:0] and extend.
  - LB (000): sign-extend byte. LBU (100): zero-extend byte.
  - LH (001): sign-extend half. LHU (101): zero-extend half.
  - LW (010), and any other funct3: full word.
  - Next state DONE.
- mem_rsp_valid outside WAIT_RSP is ignored, including stale responses after reset.
- DONE: ReadDataM holds the value (0 for stores). Next state IDLE. The instruction presented in the following IDLE cycle is the next one.
- Minimum latency with ready=1 and rsp one cycle after handshake:
  - Load: IDLE, REQ, WAIT_RSP, DONE = 3 stall cycles.
  - Store: 2 stall cycles.
- ReadDataM updates only on response capture, on entry to DONE for stores/misaligned (cleared to 0), or on reset.
- Reset mid-operation (REQ or WAIT_RSP): immediate IDLE, mem_req_valid=0 asynchronously, no retry.

Test Plan:
- LW addr 0x100, ready=1, rdata=0xDEADBEEF one cycle after handshake -> mem_addr=0x100, we=0, StallM=1 for 3 cycles, ReadDataM=0xDEADBEEF with StallM=0 in DONE.
- LB addr 0x103 and LBU addr 0x103, rdata=0x80FF1234 -> mem_addr=0x100; LB gives 0xFFFFFF80, LBU gives 0x00000080. LH addr 0x102 -> 0xFFFF80FF.
- SB addr 0x205, WriteDataM=0x000000AB, ready held 0 for 3 cycles -> valid held with stable addr=0x204, wstrb=0010, wdata=0xABABABAB; DONE one cycle after handshake, ReadDataM=0.
- LW addr 0x102 and SH addr 0x301 -> no mem_req_valid, MisalignM=1 for exactly one cycle, StallM=1 for one cycle, ReadDataM=0.
- rst_n=0 while in WAIT_RSP, then mem_rsp_valid=1 after release -> state IDLE, all outputs 0, response ignored, ReadDataM stays 0.
- Back-to-back SW 0x10 then LW 0x10 with MemReadM=MemWriteM=1 on the first instruction -> first treated as store (we=1, wstrb=1111), second issues a read, with no lost or duplicated requests.

Source files
------------

// File: rtl/mem_access_unit.sv
// Memory-stage load/store unit: aligns and issues one data-memory request per access,
// stalls the pipeline until it completes and returns the extended load result.
module mem_access_unit #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  MemReadM,
    input  logic                  MemWriteM,
    input  logic [2:0]            Funct3M,
    input  logic [DATA_WIDTH-1:0] ALUResultM,
    input  logic [DATA_WIDTH-1:0] WriteDataM,
    output logic [DATA_WIDTH-1:0] ReadDataM,
    output logic                  StallM,
    output logic                  MisalignM,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic                  mem_req_we,
    output logic [DATA_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [3:0]            mem_wstrb,
    input  logic                  mem_rsp_valid,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    localparam logic [1:0] StIdle    = 2'd0;
    localparam logic [1:0] StReq     = 2'd1;
    localparam logic [1:0] StWaitRsp = 2'd2;
    localparam logic [1:0] StDone    = 2'd3;

    logic [1:0]            state_q, state_d;
    logic [DATA_WIDTH-1:0] read_data_q, read_data_d;
    logic                  misalign_q, misalign_d;
    logic                  req_valid_q, req_valid_d;
    logic                  req_we_q, req_we_d;
    logic [DATA_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [3:0]            wstrb_q, wstrb_d;
    logic [2:0]            ld_f3_q, ld_f3_d;
    logic [1:0]            lane_q, lane_d;

    logic                  access;
    logic                  is_store;
    logic                  misaligned;
    logic [1:0]            off;
    logic [3:0]            st_strb;
    logic [DATA_WIDTH-1:0] st_data;
    logic [DATA_WIDTH-1:0] lane_word;
    logic [DATA_WIDTH-1:0] load_ext;

    assign access   = MemReadM | MemWriteM;
    assign is_store = MemWriteM;
    assign off      = ALUResultM[1:0];

    // Size comes from funct3[1:0]; encodings 10 and 11 both behave as a full word.
    always_comb begin
        misaligned = 1'b0;
        st_strb    = 4'b1111;
        st_data    = WriteDataM;
        case (Funct3M[1:0])
            2'b00: begin
                misaligned = 1'b0;
                st_strb    = 4'b0001 << off;
                st_data    = {(DATA_WIDTH/8){WriteDataM[7:0]}};
            end
            2'b01: begin
                misaligned = off[0];
                st_strb    = 4'b0011 << off;
                st_data    = {(DATA_WIDTH/16){WriteDataM[15:0]}};
            end
            default: begin
                misaligned = (off != 2'b00);
                st_strb    = 4'b1111;
                st_data    = WriteDataM;
            end
        endcase
    end

    assign lane_word = mem_rdata >> {lane_q, 3'b000};

    always_comb begin
        load_ext = lane_word;
        case (ld_f3_q)
            3'b000:  load_ext = {{(DATA_WIDTH-8){lane_word[7]}}, lane_word[7:0]};
            3'b100:  load_ext = {{(DATA_WIDTH-8){1'b0}}, lane_word[7:0]};
            3'b001:  load_ext = {{(DATA_WIDTH-16){lane_word[15]}}, lane_word[15:0]};
            3'b101:  load_ext = {{(DATA_WIDTH-16){1'b0}}, lane_word[15:0]};
            default: load_ext = mem_rdata;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        read_data_d = read_data_q;
        misalign_d  = 1'b0;
        req_valid_d = req_valid_q;
        req_we_d    = req_we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        ld_f3_d     = ld_f3_q;
        lane_d      = lane_q;

        unique case (state_q)
            StIdle: begin
                if (access) begin
                    if (misaligned) begin
                        state_d     = StDone;
                        misalign_d  = 1'b1;
                        read_data_d = '0;
                    end else begin
                        state_d     = StReq;
                        req_valid_d = 1'b1;
                        req_we_d    = is_store;
                        addr_d      = {ALUResultM[DATA_WIDTH-1:2], 2'b00};
                        wstrb_d     = is_store ? st_strb : 4'b0000;
                        wdata_d     = is_store ? st_data : '0;
                        ld_f3_d     = Funct3M;
                        lane_d      = off;
                    end
                end
            end
            StReq: begin
                if (req_valid_q && mem_req_ready) begin
                    req_valid_d = 1'b0;
                    if (req_we_q) begin
                        state_d     = StDone;
                        read_data_d = '0;
                    end else begin
                        state_d = StWaitRsp;
                    end
                end
            end
            StWaitRsp: begin
                if (mem_rsp_valid) begin
                    state_d     = StDone;
                    read_data_d = load_ext;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            read_data_q <= '0;
            misalign_q  <= 1'b0;
            req_valid_q <= 1'b0;
            req_we_q    <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= 4'b0000;
            ld_f3_q     <= 3'b000;
            lane_q      <= 2'b00;
        end else begin
            state_q     <= state_d;
            read_data_q <= read_data_d;
            misalign_q  <= misalign_d;
            req_valid_q <= req_valid_d;
            req_we_q    <= req_we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            ld_f3_q     <= ld_f3_d;
            lane_q      <= lane_d;
        end
    end

    // DONE releases the stall so the writeback register captures ReadDataM that cycle.
    assign StallM = ((state_q == StIdle) && access) ||
                    (state_q == StReq) || (state_q == StWaitRsp);

    assign ReadDataM     = read_data_q;
    assign MisalignM     = misalign_q;
    assign mem_req_valid = req_valid_q;
    assign mem_req_we    = req_we_q;
    assign mem_addr      = addr_q;
    assign mem_wdata     = wdata_q;
    assign mem_wstrb     = wstrb_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized bench for mem_access_unit: a transaction-level model predicts request fields,
// stall length and load results; a responder with random delays plays data memory.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        MemReadM, MemWriteM;
    logic [2:0]  Funct3M;
    logic [31:0] ALUResultM, WriteDataM;
    logic [31:0] ReadDataM;
    logic        StallM, MisalignM;
    logic        mem_req_valid, mem_req_ready, mem_req_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_rsp_valid;
    logic [31:0] mem_rdata;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    logic [31:0] last_rd = 32'h0;

    mem_access_unit #(.DATA_WIDTH(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .MemReadM     (MemReadM),
        .MemWriteM    (MemWriteM),
        .Funct3M      (Funct3M),
        .ALUResultM   (ALUResultM),
        .WriteDataM   (WriteDataM),
        .ReadDataM    (ReadDataM),
        .StallM       (StallM),
        .MisalignM    (MisalignM),
        .mem_req_valid(mem_req_valid),
        .mem_req_ready(mem_req_ready),
        .mem_req_we   (mem_req_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_wstrb    (mem_wstrb),
        .mem_rsp_valid(mem_rsp_valid),
        .mem_rdata    (mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic int unsigned acc_bytes(input logic [2:0] f3);
        case (f3)
            3'd0, 3'd4: return 1;
            3'd1, 3'd5: return 2;
            default:    return 4;
        endcase
    endfunction

    function automatic logic [31:0] load_result(input logic [2:0] f3, input int unsigned off,
                                                input logic [31:0] word);
        logic [31:0] v;
        v = word >> (8 * off);
        case (f3)
            3'd0, 3'd4: begin
                v = v % 256;
                if (f3 == 3'd0 && v >= 128) v = v + 32'hFFFF_FF00;
            end
            3'd1, 3'd5: begin
                v = v % 65536;
                if (f3 == 3'd1 && v >= 32768) v = v + 32'hFFFF_0000;
            end
            default: v = word;
        endcase
        return v;
    endfunction

    // Runs one access; entered #1 after a clock edge with the unit idle.
    task automatic run_txn(input bit rd, input bit wr, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wd,
                           input int unsigned rdly, input int unsigned wdly,
                           input logic [31:0] rword);
        int unsigned n, off, exp_stall, vcnt, wcnt, hs;
        bit          mis, done, got_rsp;
        int          ph;
        logic [31:0] exp_rd, exp_strb, exp_wdata;
        n         = acc_bytes(f3);
        off       = addr % 4;
        mis       = (addr % n) != 0;
        exp_rd    = (mis || wr) ? 32'h0 : load_result(f3, off, rword);
        exp_stall = mis ? 1 : (wr ? rdly + 2 : rdly + wdly + 3);
        exp_strb  = wr ? (((32'h1 << n) - 1) << off) : 32'h0;
        exp_wdata = (n == 1) ? (wd % 256) * 32'h0101_0101 :
                    (n == 2) ? (wd % 65536) * 32'h0001_0001 : wd;
        ph = 0; vcnt = 0; wcnt = 0; hs = 0; done = 0;

        check_eq("misalign_pulse_end", 32'(MisalignM), 32'h0);
        check_eq("readdata_hold", ReadDataM, last_rd);
        MemReadM = rd; MemWriteM = wr; Funct3M = f3; ALUResultM = addr; WriteDataM = wd;

        for (int k = 0; k < 64 && !done; k++) begin
            if (k > 0) begin
                @(posedge clk);
                #1;
            end
            got_rsp = 1'b0;
            if (ph == 0 && mem_req_valid) begin
                mem_req_ready = (vcnt >= rdly);
                vcnt++;
            end else begin
                mem_req_ready = 1'($urandom_range(0, 1));
            end
            if (ph == 1) begin
                mem_rsp_valid = (wcnt == wdly);
                mem_rdata     = mem_rsp_valid ? rword : $urandom;
                got_rsp       = mem_rsp_valid;
                wcnt++;
            end else begin
                mem_rsp_valid = 1'($urandom_range(0, 1));
                mem_rdata     = $urandom;
            end
            #1;
            if (!StallM) begin
                done = 1'b1;
                check_eq("stall_cycles", 32'(k), 32'(exp_stall));
                check_eq("readdata", ReadDataM, exp_rd);
                check_eq("misalign", 32'(MisalignM), 32'(mis));
                check_eq("valid_in_done", 32'(mem_req_valid), 32'h0);
                check_eq("handshakes", 32'(hs), mis ? 32'h0 : 32'h1);
            end else if (mem_req_valid) begin
                check_eq("req_addr", mem_addr, {addr[31:2], 2'b00});
                check_eq("req_we", 32'(mem_req_we), 32'(wr));
                check_eq("req_wstrb", 32'(mem_wstrb), exp_strb);
                if (wr) check_eq("req_wdata", mem_wdata, exp_wdata);
                if (mem_req_ready) begin
                    hs++;
                    if (ph == 0) ph = wr ? 2 : 1;
                end
            end
            if (got_rsp) ph = 2;
        end
        check_eq("txn_timeout", 32'(done), 32'h1);
        last_rd = exp_rd;
        mem_rsp_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_gap();
        MemReadM = 1'b0; MemWriteM = 1'b0;
        mem_rsp_valid = 1'($urandom_range(0, 1));
        mem_rdata = $urandom;
        #1;
        check_eq("idle_no_stall", 32'(StallM), 32'h0);
        @(posedge clk);
        #1;
        mem_rsp_valid = 1'b0;
    endtask

    // Reset in REQ (in_wait=0) or WAIT_RSP (in_wait=1), then a stale response.
    task automatic reset_mid(input bit in_wait);
        MemReadM = 1'b1; MemWriteM = 1'b0; Funct3M = 3'b010; ALUResultM = 32'h40;
        mem_req_ready = in_wait; mem_rsp_valid = 1'b0;
        @(posedge clk);
        #1;
        check_eq("rst_pre_valid", 32'(mem_req_valid), 32'h1);
        if (in_wait) begin
            @(posedge clk);
            #1;
            check_eq("rst_pre_wait", 32'(mem_req_valid), 32'h0);
        end
        MemReadM = 1'b0;
        rst_n = 1'b0;
        #1;
        check_eq("rst_async_valid", 32'(mem_req_valid), 32'h0);
        check_eq("rst_async_stall", 32'(StallM), 32'h0);
        check_eq("rst_async_rdata", ReadDataM, 32'h0);
        check_eq("rst_async_addr", mem_addr, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        mem_rsp_valid = 1'b1;
        mem_rdata = 32'h1234_5678;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check_eq("stale_rsp_rdata", ReadDataM, 32'h0);
            check_eq("stale_rsp_stall", 32'(StallM), 32'h0);
            check_eq("stale_rsp_valid", 32'(mem_req_valid), 32'h0);
        end
        mem_rsp_valid = 1'b0;
        last_rd = 32'h0;
    endtask

    initial begin
        rst_n = 1'b0;
        MemReadM = 1'b0; MemWriteM = 1'b0; Funct3M = 3'b000;
        ALUResultM = 32'h0; WriteDataM = 32'h0;
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        repeat (2) @(posedge clk);
        #1;
        check_eq("reset_rdata", ReadDataM, 32'h0);
        check_eq("reset_misalign", 32'(MisalignM), 32'h0);
        check_eq("reset_valid", 32'(mem_req_valid), 32'h0);
        check_eq("reset_we", 32'(mem_req_we), 32'h0);
        check_eq("reset_addr", mem_addr, 32'h0);
        check_eq("reset_wdata", mem_wdata, 32'h0);
        check_eq("reset_wstrb", 32'(mem_wstrb), 32'h0);
        check_eq("reset_stall", 32'(StallM), 32'h0);
        rst_n = 1'b1;
        mem_rsp_valid = 1'b0;
        @(posedge clk);
        #1;

        run_txn(1, 0, 3'b010, 32'h100, 32'h0, 0, 0, 32'hDEAD_BEEF);
        run_txn(1, 0, 3'b000, 32'h103, 32'h0, 0, 0, 32'h80FF_1234);
        run_txn(1, 0, 3'b100, 32'h103, 32'h0, 0, 0, 32'h80FF_1234);
        run_txn(1, 0, 3'b001, 32'h102, 32'h0, 0, 0, 32'h80FF_1234);
        run_txn(0, 1, 3'b000, 32'h205, 32'h0000_00AB, 3, 0, 32'h0);
        run_txn(1, 0, 3'b010, 32'h102, 32'h0, 0, 0, 32'h5555_5555);
        run_txn(0, 1, 3'b001, 32'h301, 32'hCAFE, 0, 0, 32'h0);
        run_txn(1, 1, 3'b010, 32'h10, 32'h0BAD_F00D, 0, 0, 32'h0);
        run_txn(1, 0, 3'b010, 32'h10, 32'h0, 0, 0, 32'h0BAD_F00D);

        reset_mid(1'b1);
        reset_mid(1'b0);

        for (int t = 0; t < 300; t++) begin
            bit          rd, wr;
            int unsigned kind, n;
            logic [2:0]  f3;
            logic [31:0] addr;
            kind = $urandom_range(0, 3);
            wr   = (kind == 1 || kind == 2);
            rd   = (kind != 1);
            f3   = wr ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 7));
            n    = acc_bytes(f3);
            addr = $urandom;
            if ($urandom_range(0, 3) != 0) addr = addr - (addr % n);
            run_txn(rd, wr, f3, addr, $urandom, $urandom_range(0, 3), $urandom_range(0, 3),
                    $urandom);
            if ($urandom_range(0, 3) == 0) idle_gap();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
